// File: rtl/irq_pkg.sv
// Shared register map and encodings for the interrupt controller.
package irq_pkg;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_MODE = 2'd2;
  localparam logic [1:0] REG_ID   = 2'd3;

  localparam logic MODE_EDGE  = 1'b1;
  localparam logic MODE_LEVEL = 1'b0;

  localparam int unsigned ID_VALID_BIT = 31;
  localparam int unsigned ID_IDX_W     = 5;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over NSRC request lines; purely combinational.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int unsigned NSRC = 6
) (
  input  logic [NSRC-1:0]     req,
  output logic                valid,
  output logic [ID_IDX_W-1:0] index
);

  always_comb begin
    valid = |req;
    index = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (req[i]) index = ID_IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: per-source edge/level latching, masking, priority ID.
// Define IRQ_CTRL_SYNC_EN to add a 2-flop synchronizer on every source line.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned     NSRC     = 6,
  parameter logic [NSRC-1:0] MODE_RST = {NSRC{1'b1}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            sel,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [NSRC-1:0] hw_int,
  output logic            irq_any
);

  logic [NSRC-1:0] src_in;
  logic [NSRC-1:0] src_r_q, src_p_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mode_q;
  logic [NSRC-1:0] w1c, rise;
  logic            wr;
  logic            id_valid;
  logic [ID_IDX_W-1:0] id_index;
  logic            unused_wdata;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
    end
  end

  assign src_in = sync2_q;
`else
  assign src_in = src;
`endif

  assign wr           = sel & we;
  assign w1c          = (wr && addr == REG_PEND) ? wdata[NSRC-1:0] : '0;
  assign rise         = src_r_q & ~src_p_q;
  assign unused_wdata = ^wdata[31:NSRC];

  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < int'(NSRC); i++) begin
      unique case (mode_q[i])
        // Set after clear so a rise in the same cycle as W1C keeps the bit.
        MODE_EDGE:  pend_d[i] = (pend_q[i] & ~w1c[i]) | rise[i];
        MODE_LEVEL: pend_d[i] = src_r_q[i];
        default:    pend_d[i] = pend_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_r_q <= '0;
      src_p_q <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= MODE_RST;
    end else begin
      src_r_q <= src_in;
      src_p_q <= src_r_q;
      pend_q  <= pend_d;
      if (wr && addr == REG_MASK) mask_q <= wdata[NSRC-1:0];
      if (wr && addr == REG_MODE) mode_q <= wdata[NSRC-1:0];
    end
  end

  assign hw_int  = pend_q & mask_q;
  assign irq_any = |hw_int;

  irq_prio_enc #(
    .NSRC (NSRC)
  ) u_prio_enc (
    .req   (hw_int),
    .valid (id_valid),
    .index (id_index)
  );

  always_comb begin
    rdata = '0;
    unique case (addr)
      REG_PEND: rdata[NSRC-1:0] = pend_q;
      REG_MASK: rdata[NSRC-1:0] = mask_q;
      REG_MODE: rdata[NSRC-1:0] = mode_q;
      REG_ID: begin
        rdata[ID_VALID_BIT]   = id_valid;
        rdata[ID_IDX_W-1:0]   = id_index;
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed literal checks plus randomized traffic vs a model.
module tb_irq_ctrl;

  localparam int NSRC = 6;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int SD = LAT - 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  src   = '0;
  logic        sel   = 1'b0;
  logic        we    = 1'b0;
  logic [1:0]  addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [5:0]  hw_int;
  logic        irq_any;

  always #5 clk = ~clk;

  irq_ctrl #(
    .NSRC     (NSRC),
    .MODE_RST (6'h3F)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .src     (src),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .hw_int  (hw_int),
    .irq_any (irq_any)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: h[0] is src as sampled at the most recent edge.
  bit [5:0] h [0:5];
  bit [5:0] m_pend, m_mask, m_mode;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] r;
    bit [5:0]    act;
    bit          found;
    r     = '0;
    act   = m_pend & m_mask;
    found = 1'b0;
    case (a)
      2'd0: r = 32'(m_pend);
      2'd1: r = 32'(m_mask);
      2'd2: r = 32'(m_mode);
      default: begin
        for (int i = 0; i < 6; i++) begin
          if (act[i] && !found) begin
            r     = 32'h8000_0000 | 32'(i);
            found = 1'b1;
          end
        end
      end
    endcase
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        for (int i = 0; i < 6; i++) h[i] = '0;
        m_pend = '0;
        m_mask = '0;
        m_mode = 6'h3F;
      end else begin : upd
        bit [5:0] sr, sp, clr;
        sr  = h[SD];
        sp  = h[SD+1];
        clr = (sel && we && addr == 2'd0) ? wdata[5:0] : 6'd0;
        for (int i = 0; i < 6; i++) begin
          if (m_mode[i]) m_pend[i] = (m_pend[i] && !clr[i]) || (sr[i] && !sp[i]);
          else           m_pend[i] = sr[i];
        end
        if (sel && we && addr == 2'd1) m_mask = wdata[5:0];
        if (sel && we && addr == 2'd2) m_mode = wdata[5:0];
        for (int i = 5; i > 0; i--) h[i] = h[i-1];
        h[0] = src;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        check("cmp_hw_int", 32'(hw_int), 32'(m_pend & m_mask));
        check("cmp_irq_any", 32'(irq_any), 32'(|(m_pend & m_mask)));
        check("cmp_rdata", rdata, m_read(addr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    sel = 1'b0;
    we  = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  initial begin
    // Reset with all sources high.
    reset = 1'b0;
    src   = 6'h3F;
    repeat (3) tick();
    check_en = 1'b1;
    check("rst_hw_int", 32'(hw_int), 32'h0);
    check("rst_irq_any", 32'(irq_any), 32'h0);
    rd_check("rst_pend", 2'd0, 32'h0);
    rd_check("rst_mode", 2'd2, 32'h3F);
    rd_check("rst_mask", 2'd1, 32'h0);
    reset = 1'b1;
    repeat (LAT - 1) tick();
    rd_check("pend_early", 2'd0, 32'h0);
    tick();
    rd_check("pend_lat", 2'd0, 32'h3F);
    check("masked_hw_int", 32'(hw_int), 32'h0);
    src = 6'h00;
    wr(2'd0, 32'h3F);

    // Single edge pulse on src[2].
    wr(2'd1, 32'h3F);
    src = 6'h04;
    tick();
    src = 6'h00;
    repeat (LAT - 1) tick();
    check("pulse_hw_int", 32'(hw_int), 32'h04);
    rd_check("pulse_id", 2'd3, 32'h8000_0002);
    repeat (3) tick();
    check("pulse_held", 32'(hw_int), 32'h04);
    wr(2'd0, 32'hABCD_0004);
    check("w1c_hw_int", 32'(hw_int), 32'h0);

    // Priority between src[1] and src[4].
    src = 6'h12;
    tick();
    src = 6'h00;
    repeat (LAT - 1) tick();
    rd_check("prio_id1", 2'd3, 32'h8000_0001);
    wr(2'd0, 32'h02);
    rd_check("prio_id4", 2'd3, 32'h8000_0004);
    wr(2'd0, 32'h10);
    rd_check("prio_none", 2'd3, 32'h0);

    // Level mode: PEND follows src delayed, W1C ignored.
    wr(2'd2, 32'h0);
    for (int j = 1; j <= LAT + 7; j++) begin
      src = (j <= 5) ? 6'h08 : 6'h00;
      if (j == LAT + 2) begin
        sel   = 1'b1;
        we    = 1'b1;
        addr  = 2'd0;
        wdata = 32'h08;
      end
      tick();
      sel = 1'b0;
      we  = 1'b0;
      rd_check("level_pend", 2'd0, (j >= LAT && j <= LAT + 4) ? 32'h08 : 32'h0);
    end
    wr(2'd3, 32'hFFFF_FFFF);
    rd_check("id_write_ignored", 2'd1, 32'h3F);

    // Edge mode: rise and W1C on the same edge, set wins.
    wr(2'd2, 32'h3F);
    src = 6'h01;
    tick();
    src = 6'h00;
    repeat (LAT - 2) tick();
    wr(2'd0, 32'h01);
    rd_check("set_wins", 2'd0, 32'h01);
    wr(2'd0, 32'h01);
    rd_check("w1c_clears", 2'd0, 32'h0);

    // Asynchronous reset mid-cycle with PEND = 0x15.
    src = 6'h15;
    tick();
    src = 6'h00;
    repeat (LAT) tick();
    rd_check("pend15", 2'd0, 32'h15);
    #1;
    reset = 1'b0;
    #1;
    check("async_hw_int", 32'(hw_int), 32'h0);
    check("async_irq_any", 32'(irq_any), 32'h0);
    check("async_pend", rdata, 32'h0);
    tick();
    reset = 1'b1;
    tick();

    // Randomized traffic against the model.
    repeat (600) begin
      src   = 6'($urandom);
      sel   = ($urandom_range(0, 3) == 0);
      we    = 1'($urandom);
      addr  = 2'($urandom);
      wdata = $urandom;
      tick();
    end
    sel = 1'b0;
    we  = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
